mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word memory answering one load/store per request after WAIT wait states
module mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAITS, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   wd_q;
  logic [31:0]   rd_q;
  logic          ready_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          enter_resp;
  logic          fin_we;
  logic [31:0]   fin_adr;
  logic          fin_bad;
  logic [AW-1:0] fin_idx;

  // With WAIT=0 the access enters RESP on its acceptance edge, before adr_q holds it.
  always_comb begin
    fin_we     = (state_q == IDLE) ? we  : we_q;
    fin_adr    = (state_q == IDLE) ? adr : adr_q;
    fin_bad    = (fin_adr[1:0] != 2'b00) || (fin_adr[31:AW+2] != '0);
    fin_idx    = fin_adr[AW+1:2];
    enter_resp = ((state_q == IDLE) && req && (WAIT == 0)) ||
                 ((state_q == WAITS) && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q  <= we;
            adr_q <= adr;
            wd_q  <= wd;
            if (WAIT == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAITS;
              cnt_q   <= WAIT_LD;
            end
          end
        end
        WAITS: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (enter_resp) begin
        ready_q <= 1'b1;
        err_q   <= fin_bad;
        if (!fin_we && !fin_bad) begin
          rd_q <= mem_q[fin_idx];
        end
      end
    end
  end

  // Storage is never reset; a reset during RESP abandons the write.
  always_ff @(posedge clk) begin
    if (reset && (state_q == RESP) && we_q && !err_q) begin
      mem_q[adr_q[AW+1:2]] <= wd_q;
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule
